// File: rtl/hex_display_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl_pkg : shared types and constants for the display controller
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package hex_display_ctrl_pkg;

  typedef enum logic [0:0] {
    READY = 1'b0,
    HOLD  = 1'b1
  } state_t;

  localparam logic REQ_A = 1'b0;
  localparam logic REQ_B = 1'b1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;

endpackage

`default_nettype wire

// File: rtl/hex_display_ctrl_seg7.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl_seg7 : hex nibble to active-low 7-segment pattern {g..a}
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hex_display_ctrl_seg7 (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  // Lowercase glyphs for b, c and d keep them distinct from 8, 0/C and 0.
  always_comb begin
    case (nibble)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b0100111;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      default: seg = 7'b0001110;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// hex_display_ctrl : two-requester round-robin display owner with hold-off,
//                    leading-zero blanking, per-digit blink, registered segs
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module hex_display_ctrl
  import hex_display_ctrl_pkg::*;
#(
  parameter int NUM_DIGITS  = 6,
  parameter int HOLD_CYCLES = 16,
  parameter int BLINK_DIV   = 25000000
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    a_valid,
  input  logic [4*NUM_DIGITS-1:0] a_data,
  output logic                    a_ready,
  input  logic                    b_valid,
  input  logic [4*NUM_DIGITS-1:0] b_data,
  output logic                    b_ready,
  input  logic                    lz_en,
  input  logic [NUM_DIGITS-1:0]   blink_mask,
  output logic                    owner,
  output logic [7*NUM_DIGITS-1:0] hex
);

  localparam int DW = 4 * NUM_DIGITS;
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  state_t                       state;
  logic [DW-1:0]                value;
  logic                         last_grant;
  logic [HW-1:0]                hold_cnt;
  logic [BW-1:0]                blink_cnt;
  logic                         blink_phase;
  logic                         grant;
  logic                         accept;
  logic [NUM_DIGITS-1:0][6:0]   dec_seg;
  logic [7*NUM_DIGITS-1:0]      next_hex;
  logic                         zero_above;

  always_comb begin
    if (a_valid && b_valid) grant = ~last_grant;
    else if (b_valid)       grant = REQ_B;
    else                    grant = REQ_A;
  end

  // Readies are gated by rst_n so they drop immediately when reset asserts.
  assign a_ready = rst_n && (state == READY) && a_valid && (grant == REQ_A);
  assign b_ready = rst_n && (state == READY) && b_valid && (grant == REQ_B);
  assign accept  = a_ready || b_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= READY;
      value      <= '0;
      owner      <= REQ_A;
      last_grant <= REQ_B;
      hold_cnt   <= '0;
    end else begin
      case (state)
        READY: begin
          if (accept) begin
            value      <= (grant == REQ_B) ? b_data : a_data;
            owner      <= grant;
            last_grant <= grant;
            hold_cnt   <= HW'(HOLD_CYCLES - 1);
            state      <= HOLD;
          end
        end
        HOLD: begin
          if (hold_cnt == '0) state <= READY;
          else                hold_cnt <= hold_cnt - 1'b1;
        end
        default: state <= READY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == BW'(BLINK_DIV - 1)) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt   <= blink_cnt + 1'b1;
    end
  end

  for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_dec
    hex_display_ctrl_seg7 u_seg7 (
      .nibble (value[4*i +: 4]),
      .seg    (dec_seg[i])
    );
  end

  // Scan from the top digit down; digit 0 is exempt so a zero value shows "0".
  always_comb begin
    zero_above = 1'b1;
    next_hex   = '1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above = zero_above && (value[4*i +: 4] == 4'h0);
      if ((lz_en && zero_above && (i != 0)) || (blink_mask[i] && blink_phase))
        next_hex[7*i +: 7] = SEG_BLANK;
      else
        next_hex[7*i +: 7] = dec_seg[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) hex <= '1;
    else        hex <= next_hex;
  end

endmodule

`default_nettype wire

// File: tb/tb_hex_display_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hex_display_ctrl : scoreboard bench for hex_display_ctrl
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_hex_display_ctrl;

  localparam int ND = 6;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          a_valid, b_valid, a_ready, b_ready;
  logic [23:0]   a_data, b_data;
  logic          lz_en;
  logic [ND-1:0] blink_mask;
  logic          owner;
  logic [41:0]   hex;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  typedef struct {
    string       tag;
    logic        owner;
    logic [41:0] hex;
  } exp_t;
  exp_t sb[$];

  hex_display_ctrl #(.NUM_DIGITS(ND), .HOLD_CYCLES(16), .BLINK_DIV(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_valid(a_valid), .a_data(a_data), .a_ready(a_ready),
    .b_valid(b_valid), .b_data(b_data), .b_ready(b_ready),
    .lz_en(lz_en), .blink_mask(blink_mask),
    .owner(owner), .hex(hex)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    logic [6:0] t [16];
    t = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
          7'h00, 7'h10, 7'h08, 7'h03, 7'h27, 7'h21, 7'h06, 7'h0E};
    return t[n];
  endfunction

  function automatic logic [41:0] model(input logic [23:0] v, input logic lz,
                                        input logic [5:0] mask, input logic ph);
    logic [41:0] r;
    bit          lead = 1'b1;
    for (int d = 5; d >= 0; d--) begin
      lead = lead && (v[4*d +: 4] == 4'h0);
      r[7*d +: 7] = ((lz && lead && d > 0) || (mask[d] && ph)) ? 7'h7F : ref_seg(v[4*d +: 4]);
    end
    return r;
  endfunction

  task automatic push(input string tag, input logic own, input logic [41:0] h);
    exp_t e;
    e.tag = tag; e.owner = own; e.hex = h;
    sb.push_back(e);
  endtask

  task automatic pop_compare();
    exp_t e;
    if (sb.size() == 0) begin
      check("sb_empty", 64'd0, 64'd1);
      return;
    end
    e = sb.pop_front();
    check({e.tag, "_hex"}, 64'(hex), 64'(e.hex));
    check({e.tag, "_owner"}, 64'(owner), 64'(e.owner));
  endtask

  // Called at a negedge; returns at negedge+1 with a ready visible.
  task automatic wait_grant(output logic who, output bit ok);
    ok = 1'b0; who = 1'b0;
    for (int n = 0; n < 40; n++) begin
      #1;
      if (a_ready || b_ready) begin
        who = b_ready; ok = 1'b1;
        return;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic       who, ph;
    bit         ok;
    int         k, run, last_acc;
    logic [6:0] prev;
    logic [23:0] nxt;

    rst_n = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
    a_data = '0; b_data = '0; lz_en = 1'b1; blink_mask = '0;

    #12;
    check("rst_hex", 64'(hex), 64'(42'h3FF_FFFF_FFFF));
    check("rst_ready", 64'({a_ready, b_ready}), 64'd0);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); @(negedge clk);
    check("rel_hex", 64'(hex), 64'({35'h7_FFFF_FFFF, 7'b1000000}));
    check("rel_owner", 64'(owner), 64'd0);

    // single requester
    a_valid = 1'b1; a_data = 24'h00C0DE;
    #1;
    check("single_a_ready", 64'(a_ready), 64'd1);
    check("single_b_ready", 64'(b_ready), 64'd0);
    push("single", 1'b0, {7'h7F, 7'h7F, 7'b0100111, 7'b1000000, 7'b0100001, 7'b0000110});
    @(posedge clk); #1;
    k = cyc;
    a_valid = 1'b0; a_data = 24'hFFFFFF;
    @(posedge clk); @(negedge clk);
    pop_compare();

    // hold-off: B arrives 3 cycles after A's accept
    @(negedge clk);
    b_valid = 1'b1; b_data = 24'h123456;
    push("holdoff", 1'b1, model(24'h123456, 1'b1, 6'd0, 1'b0));
    for (int n = 0; n < 40; n++) begin
      #1;
      if (b_ready) break;
      if (n == 2) b_data = 24'hFFFFFF;
      if (n == 4) b_data = 24'h123456;
      @(negedge clk);
    end
    check("holdoff_ready", 64'(b_ready), 64'd1);
    check("holdoff_gap", 64'(cyc + 1 - k), 64'd17);
    @(posedge clk); #1;
    b_valid = 1'b0; b_data = 24'h0;
    @(posedge clk); @(negedge clk);
    pop_compare();

    // blink on digit 0
    blink_mask = 6'b000001;
    @(posedge clk); @(negedge clk);
    prev = hex[6:0];
    ok = 1'b0;
    for (int n = 0; n < 12; n++) begin
      @(posedge clk); @(negedge clk);
      if (hex[6:0] !== prev) begin ok = 1'b1; break; end
    end
    check("blink_toggle_seen", 64'(ok), 64'd1);
    ph = (hex[6:0] == 7'h7F);
    run = 0;
    check("blink_hex", 64'(hex), 64'(model(24'h123456, 1'b1, 6'b000001, ph)));
    for (int n = 0; n < 16; n++) begin
      @(posedge clk); @(negedge clk);
      run++;
      if (run == 4) begin ph = ~ph; run = 0; end
      check("blink_hex", 64'(hex), 64'(model(24'h123456, 1'b1, 6'b000001, ph)));
    end
    blink_mask = '0;

    // leading zeros
    a_valid = 1'b1; a_data = 24'h000000;
    wait_grant(who, ok);
    if (!ok) check("lz_grant_timeout", 64'd0, 64'd1);
    check("lz_who", 64'(who), 64'd0);
    push("lz_on", 1'b0, {35'h7_FFFF_FFFF, 7'b1000000});
    @(posedge clk); #1; a_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    pop_compare();
    lz_en = 1'b0;
    push("lz_off", 1'b0, {6{7'b1000000}});
    @(posedge clk); @(negedge clk);
    pop_compare();

    // reset mid-HOLD, then contention from reset
    a_valid = 1'b1; b_valid = 1'b1; a_data = 24'h0000A1; b_data = 24'h0000B2;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_hex", 64'(hex), 64'(42'h3FF_FFFF_FFFF));
    check("midrst_ready", 64'({a_ready, b_ready}), 64'd0);
    lz_en = 1'b1;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    last_acc = 0;
    for (int g = 0; g < 4; g++) begin
      wait_grant(who, ok);
      if (!ok) check("cont_grant_timeout", 64'd0, 64'd1);
      check("cont_who", 64'(who), 64'(g % 2));
      if (g > 0) check("cont_gap", 64'(cyc + 1 - last_acc), 64'd17);
      last_acc = cyc + 1;
      push("cont", who, model(who ? b_data : a_data, 1'b1, 6'd0, 1'b0));
      @(posedge clk); #1;
      if (g == 0) check("midrst_cleared", 64'(hex), 64'({35'h7_FFFF_FFFF, 7'b1000000}));
      if (who) begin nxt = b_data + 24'h111111; b_data = nxt; end
      else     begin nxt = a_data + 24'h101010; a_data = nxt; end
      @(posedge clk); @(negedge clk);
      pop_compare();
    end
    a_valid = 1'b0; b_valid = 1'b0;
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
